// File: rtl/fetch_inflight_tracker_pkg.sv
// ----------------------------------------------------------------------------
// fetch_inflight_tracker_pkg
//
// Shared types and constants for the fetch in-flight tracker.
//   FETCH_SUBUNIT_ID_W    : width of the encoded sub-unit index (up to 8 units)
//   FETCH_MAX_SUB_UNITS   : largest sub-unit count the encoding can represent
//   fetch_tracker_entry_t : per-request attributes captured at issue
//   one_hot_to_integer    : encodes a one-hot sub-unit select into an index
// ----------------------------------------------------------------------------
package fetch_inflight_tracker_pkg;

  localparam int FETCH_SUBUNIT_ID_W  = 3;
  localparam int FETCH_MAX_SUB_UNITS = 1 << FETCH_SUBUNIT_ID_W;

  typedef struct packed {
    logic [FETCH_SUBUNIT_ID_W-1:0] subunit_id;
    logic                          addr_valid;
    logic                          mmu_fault;
    logic                          predicted;
    logic                          is_branch;
  } fetch_tracker_entry_t;

  // OR-ing the indices of set bits gives the right answer for a one-hot
  // input and needs no priority chain; an all-zero input encodes to 0.
  function automatic logic [FETCH_SUBUNIT_ID_W-1:0] one_hot_to_integer(
    input logic [FETCH_MAX_SUB_UNITS-1:0] oneHot
  );
    logic [FETCH_SUBUNIT_ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < FETCH_MAX_SUB_UNITS; i++) begin
      if (oneHot[i]) id = id | FETCH_SUBUNIT_ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/fetch_inflight_tracker.sv
// ----------------------------------------------------------------------------
// fetch_inflight_tracker
//
// In-order tracker for outstanding instruction-fetch requests. Attributes are
// recorded at issue, returning sub-unit data is muxed back in request order,
// faulting / invalid-address requests complete without data, and responses
// belonging to requests issued before a flush are silently dropped.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : discard everything issued up to and including now
//   issue / issue_ready   : new request handshake (ready = not full)
//   issue_match           : one-hot sub-unit select, zero = invalid address
//   issue_mmu_fault       : translation fault, no sub-unit access made
//   issue_predicted       : request was a predicted branch/jump
//   issue_is_branch       : request was a predicted conditional branch
//   unit_data_valid/data  : per sub-unit response strobe and word
//   complete*             : head request delivered to decode this cycle
//   occupancy             : number of requests in flight
//   spurious_err          : sticky, a response arrived that nothing expected
// ----------------------------------------------------------------------------
module fetch_inflight_tracker
  import fetch_inflight_tracker_pkg::*;
#(
  parameter int NUM_SUB_UNITS   = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  issue,
  output logic                                  issue_ready,
  input  logic [NUM_SUB_UNITS-1:0]              issue_match,
  input  logic                                  issue_mmu_fault,
  input  logic                                  issue_predicted,
  input  logic                                  issue_is_branch,
  input  logic [NUM_SUB_UNITS-1:0]              unit_data_valid,
  input  logic [NUM_SUB_UNITS*DATA_WIDTH-1:0]   unit_data,
  output logic                                  complete,
  output logic                                  complete_ok,
  output logic [DATA_WIDTH-1:0]                 complete_data,
  output logic                                  complete_predicted,
  output logic                                  complete_is_branch,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  occupancy,
  output logic                                  spurious_err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int OCC_W = $clog2(MAX_OUTSTANDING+1);

  generate
    if (NUM_SUB_UNITS < 1 || NUM_SUB_UNITS > FETCH_MAX_SUB_UNITS) begin : g_badUnits
      $error("fetch_inflight_tracker: NUM_SUB_UNITS must be 1..8");
    end
    if (MAX_OUTSTANDING < 2 || MAX_OUTSTANDING > 16 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_badDepth
      $error("fetch_inflight_tracker: MAX_OUTSTANDING must be a power of two in 2..16");
    end
  endgenerate

  fetch_tracker_entry_t entries_q [MAX_OUTSTANDING];
  fetch_tracker_entry_t newEntry;
  fetch_tracker_entry_t head;

  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [OCC_W-1:0] occupancy_q, occupancy_d;
  logic [OCC_W-1:0] discardCount_q, discardCount_d;
  logic             spuriousErr_q, spuriousErr_d;

  logic [FETCH_MAX_SUB_UNITS-1:0] matchPad;
  logic [FETCH_MAX_SUB_UNITS-1:0] validPad;
  logic [DATA_WIDTH-1:0]          unitWord [FETCH_MAX_SUB_UNITS];

  logic empty, full, headExpectsData, pop, push, spuriousHit;

  // Widen the per-unit vectors to the full encodable range so the head's
  // subunit_id can index them directly regardless of NUM_SUB_UNITS.
  always_comb begin
    matchPad = '0;
    validPad = '0;
    matchPad[NUM_SUB_UNITS-1:0] = issue_match;
    validPad[NUM_SUB_UNITS-1:0] = unit_data_valid;
    for (int k = 0; k < FETCH_MAX_SUB_UNITS; k++) begin
      unitWord[k] = '0;
    end
    for (int k = 0; k < NUM_SUB_UNITS; k++) begin
      unitWord[k] = unit_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Head bookkeeping, retire decision and spurious-response detection.
  // A push is accepted when full only alongside a pop, which keeps the
  // tracker at full throughput without making issue_ready depend on pop.
  always_comb begin
    newEntry.subunit_id = one_hot_to_integer(matchPad);
    newEntry.addr_valid = |issue_match;
    newEntry.mmu_fault  = issue_mmu_fault;
    newEntry.predicted  = issue_predicted;
    newEntry.is_branch  = issue_is_branch;

    head            = entries_q[rdPtr_q];
    empty           = (occupancy_q == '0);
    full            = (occupancy_q == OCC_W'(MAX_OUTSTANDING));
    headExpectsData = head.addr_valid & ~head.mmu_fault;
    pop             = ~empty & (~headExpectsData | validPad[head.subunit_id]);
    push            = issue & (~full | pop);

    spuriousHit = 1'b0;
    for (int k = 0; k < NUM_SUB_UNITS; k++) begin
      if (unit_data_valid[k] &&
          (empty || head.subunit_id != FETCH_SUBUNIT_ID_W'(k) || !headExpectsData)) begin
        spuriousHit = 1'b1;
      end
    end
  end

  // Next-state for pointers, occupancy, discard counter and sticky error.
  // On flush the counter loads the post-edge occupancy, which covers a
  // same-cycle issue and excludes a same-cycle retire.
  always_comb begin
    rdPtr_d       = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    wrPtr_d       = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    occupancy_d   = occupancy_q + OCC_W'(push) - OCC_W'(pop);
    spuriousErr_d = spuriousErr_q | spuriousHit;
    discardCount_d = discardCount_q;
    if (flush) begin
      discardCount_d = occupancy_d;
    end else if (pop && discardCount_q != '0) begin
      discardCount_d = discardCount_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q        <= '0;
      wrPtr_q        <= '0;
      occupancy_q    <= '0;
      discardCount_q <= '0;
      spuriousErr_q  <= 1'b0;
    end else begin
      rdPtr_q        <= rdPtr_d;
      wrPtr_q        <= wrPtr_d;
      occupancy_q    <= occupancy_d;
      discardCount_q <= discardCount_d;
      spuriousErr_q  <= spuriousErr_d;
    end
  end

  // Attribute storage needs no reset: entries are only read while occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[wrPtr_q] <= newEntry;
    end
  end

  assign issue_ready        = (occupancy_q < OCC_W'(MAX_OUTSTANDING));
  assign complete           = pop & (discardCount_q == '0);
  assign complete_ok        = ~empty & headExpectsData;
  assign complete_data      = unitWord[head.subunit_id];
  assign complete_predicted = ~empty & head.predicted;
  assign complete_is_branch = ~empty & head.is_branch;
  assign occupancy          = occupancy_q;
  assign spurious_err       = spuriousErr_q;

endmodule

// File: tb/tb_fetch_inflight_tracker.sv
// ----------------------------------------------------------------------------
// tb_fetch_inflight_tracker
//
// Self-checking bench for fetch_inflight_tracker. A queue of outstanding
// requests (each carrying a "discarded" flag set by flush) models the tracker
// and predicts every output; directed scenarios are followed by randomized
// traffic including faults, invalid addresses, flushes, stray responses and a
// mid-run reset.
// ----------------------------------------------------------------------------
module tb_fetch_inflight_tracker;

  localparam int NSU   = 3;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int OCCW  = $clog2(DEPTH+1);

  typedef struct {
    int unsigned unit;
    bit          expects;
    bit          pred;
    bit          br;
    bit          discarded;
  } ModelEntry;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              issue;
  logic              issue_ready;
  logic [NSU-1:0]    issue_match;
  logic              issue_mmu_fault;
  logic              issue_predicted;
  logic              issue_is_branch;
  logic [NSU-1:0]    unit_data_valid;
  logic [NSU*DW-1:0] unit_data;
  logic              complete;
  logic              complete_ok;
  logic [DW-1:0]     complete_data;
  logic              complete_predicted;
  logic              complete_is_branch;
  logic [OCCW-1:0]   occupancy;
  logic              spurious_err;

  int checkCount = 0;
  int errorCount = 0;

  ModelEntry     q[$];
  bit            modelSpurious = 1'b0;
  logic [DW-1:0] unitWord [NSU];
  bit            useFixed = 1'b0;
  logic [DW-1:0] fixedWord = '0;

  always #5 clk = ~clk;

  fetch_inflight_tracker #(
    .NUM_SUB_UNITS  (NSU),
    .MAX_OUTSTANDING(DEPTH),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .issue             (issue),
    .issue_ready       (issue_ready),
    .issue_match       (issue_match),
    .issue_mmu_fault   (issue_mmu_fault),
    .issue_predicted   (issue_predicted),
    .issue_is_branch   (issue_is_branch),
    .unit_data_valid   (unit_data_valid),
    .unit_data         (unit_data),
    .complete          (complete),
    .complete_ok       (complete_ok),
    .complete_data     (complete_data),
    .complete_predicted(complete_predicted),
    .complete_is_branch(complete_is_branch),
    .occupancy         (occupancy),
    .spurious_err      (spurious_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: observed 0x%0h, expected 0x%0h",
               tag, $time, observed, expected);
    end
  endtask

  function automatic int unsigned unitOf(input logic [NSU-1:0] match);
    int unsigned u;
    u = 0;
    for (int k = 0; k < NSU; k++) if (match[k]) u = k;
    return u;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the model mid-phase, then advance the model to the next edge.
  task automatic applyStimulus(input bit iss, input logic [NSU-1:0] match,
                               input bit fault, input bit pred, input bit br,
                               input bit fl, input logic [NSU-1:0] valid);
    ModelEntry head;
    ModelEntry e;
    bit hasHead, expPop, expComplete, spurNow, accepted;
    @(negedge clk);
    rst = 1'b0;
    issue = iss;
    issue_match = match;
    issue_mmu_fault = fault;
    issue_predicted = pred;
    issue_is_branch = br;
    flush = fl;
    unit_data_valid = valid;
    for (int k = 0; k < NSU; k++) begin
      unitWord[k] = useFixed ? fixedWord : DW'($urandom);
      unit_data[k*DW +: DW] = unitWord[k];
    end
    #2;
    hasHead = (q.size() > 0);
    head = '{unit: 0, expects: 1'b0, pred: 1'b0, br: 1'b0, discarded: 1'b0};
    if (hasHead) head = q[0];
    expPop = hasHead && (!head.expects || valid[head.unit]);
    expComplete = expPop && !head.discarded;
    checkOutput("complete", complete, expComplete);
    checkOutput("complete_ok", complete_ok, hasHead && head.expects);
    checkOutput("complete_predicted", complete_predicted, head.pred);
    checkOutput("complete_is_branch", complete_is_branch, head.br);
    if (expComplete && head.expects)
      checkOutput("complete_data", complete_data, unitWord[head.unit]);
    checkOutput("occupancy", occupancy, q.size());
    checkOutput("issue_ready", issue_ready, q.size() < DEPTH);
    checkOutput("spurious_err", spurious_err, modelSpurious);

    spurNow = 1'b0;
    for (int k = 0; k < NSU; k++)
      if (valid[k] && (!hasHead || k != head.unit || !head.expects)) spurNow = 1'b1;
    accepted = iss && (q.size() < DEPTH || expPop);
    if (expPop) void'(q.pop_front());
    if (accepted) begin
      e.unit = unitOf(match);
      e.expects = (match != '0) && !fault;
      e.pred = pred;
      e.br = br;
      e.discarded = 1'b0;
      q.push_back(e);
    end
    if (fl) foreach (q[i]) q[i].discarded = 1'b1;
    if (spurNow) modelSpurious = 1'b1;
    @(posedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    issue = 1'b0;
    flush = 1'b0;
    issue_match = '0;
    issue_mmu_fault = 1'b0;
    issue_predicted = 1'b0;
    issue_is_branch = 1'b0;
    unit_data_valid = '0;
    unit_data = '0;
    @(posedge clk);
    q.delete();
    modelSpurious = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic respondHead();
    logic [NSU-1:0] v;
    v = '0;
    if (q.size() > 0 && q[0].expects) v[q[0].unit] = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, v);
  endtask

  initial begin
    logic [NSU-1:0] m;
    logic [NSU-1:0] v;
    bit iss, fl, flt;
    int unsigned sel;

    doReset();
    idle();

    // Fill to depth on unit 1, then answer in order with fixed words.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 3'b010, 1'b0, i[0], i[1], 1'b0, '0);
    idle();
    useFixed = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      fixedWord = 32'hA0 + i;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    end
    idle();

    // Unit 0 then unit 2; unit 2 answers twice, the second is stray.
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    fixedWord = 32'h13;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    useFixed = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
    idle();

    // Flush with a same-cycle issue; all four stale answers are dropped.
    doReset();
    idle();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < DEPTH; i++) respondHead();
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    respondHead();
    idle();

    // Faulting and invalid-address requests complete without any strobe.
    applyStimulus(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle();
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle();
    idle();

    // Full throughput: keep four in flight, issue and retire every cycle.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, NSU'(1 << $urandom_range(0, NSU-1)), 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 100; i++) begin
      v = '0;
      v[q[0].unit] = 1'b1;
      applyStimulus(1'b1, NSU'(1 << $urandom_range(0, NSU-1)), 1'b0,
                    1'($urandom), 1'($urandom), 1'b0, v);
    end
    for (int i = 0; i < DEPTH; i++) respondHead();
    idle();

    // Randomized traffic with flushes, faults, stray strobes and a reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        doReset();
      end
      iss = (q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, NSU);
      m = (sel == NSU) ? '0 : NSU'(1 << sel);
      flt = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 19) == 0);
      v = '0;
      if (q.size() > 0 && q[0].expects && $urandom_range(0, 2) != 0) v[q[0].unit] = 1'b1;
      if ($urandom_range(0, 29) == 0) v[$urandom_range(0, NSU-1)] = 1'b1;
      applyStimulus(iss, m, flt, 1'($urandom), 1'($urandom), fl, v);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fetch_inflight_tracker.md
# fetch_inflight_tracker

Parametrised in-order tracker for outstanding instruction-fetch requests across up to NUM_SUB_UNITS memory sub-units (local mem, icache, bus), supporting MAX_OUTSTANDING requests in flight. It sits between fetch issue control and decode. It records per-request attributes at issue, muxes the returning sub-unit data in request order, and synthesises completions for faulting or invalid-address requests. After a flush it silently discards the stale responses still in flight. It generalises the fixed two-deep attribute/flush-count logic to arbitrary depth and adds occupancy reporting and sticky spurious-response detection.

## Interface
- NUM_SUB_UNITS, 3, number of fetch sub-units (1..8)
- MAX_OUTSTANDING, 4, maximum requests in flight (power of two, 2..16)
- DATA_WIDTH, 32, instruction word width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all requests issued up to and including this cycle
- issue  in  1  new request issued this cycle (must be 0 when issue_ready=0)
- issue_ready  out  1  tracker not full
- issue_match  in  NUM_SUB_UNITS  one-hot sub-unit select; all-zero = invalid address
- issue_mmu_fault  in  1  translation fault; no sub-unit request made
- issue_predicted  in  1  request was a predicted branch/jump
- issue_is_branch  in  1  request was a predicted conditional branch
- unit_data_valid  in  NUM_SUB_UNITS  per-unit response strobe
- unit_data  in  NUM_SUB_UNITS×DATA_WIDTH  per-unit response data
- complete  out  1  head request retired and delivered to decode
- complete_ok  out  1  1 = valid instruction; 0 = access fault
- complete_data  out  DATA_WIDTH  instruction word (don't-care when complete_ok=0)
- complete_predicted  out  1  attribute of delivered request
- complete_is_branch  out  1  attribute of delivered request
- occupancy  out  $clog2(MAX_OUTSTANDING+1)  entries in flight
- spurious_err  out  1  sticky: a response arrived when the head did not expect one

## Operation
- Attribute FIFO, depth MAX_OUTSTANDING. Entry fields: subunit_id (encoded from issue_match), addr_valid (|issue_match), mmu_fault, predicted, is_branch. Push on issue.
- Head retire (pop) conditions:
  - Head has addr_valid & ~mmu_fault: retire when unit_data_valid[subunit_id].
  - Otherwise (fault or invalid address): retire as soon as it is at the head, with no data.
- complete = pop & (discard_count==0).
  - complete_ok = addr_valid & ~mmu_fault.
  - complete_data = unit_data[head subunit_id].
- occupancy_next = occupancy + issue − pop. issue_ready = occupancy < MAX_OUTSTANDING. A pop and a push may occur in the same cycle when full; issue_ready stays combinationally independent of pop.
- Discard counter:
  - On flush: discard_count ← occupancy_next, so a same-cycle issue is also discarded and a same-cycle pop is excluded from the count.
  - Else if pop & discard_count≠0: decrement.
  - A flush while the counter is nonzero reloads it. It never underflows.
- spurious_err sets when unit_data_valid[k] and (FIFO empty, or k≠head subunit_id, or head is a fault/invalid entry). It clears only on rst.
- No backpressure from decode: each completion is consumed in the cycle it is presented.

## Timing
- Reset values:
  - issue_ready=1, complete=0, occupancy=0, spurious_err=0.
  - discard_count=0, FIFO empty.
  - complete_ok, complete_predicted, complete_is_branch read 0 while empty.
- Data path latency: unit_data_valid → complete is combinational (same cycle).
- Fault/invalid entry: earliest complete is the cycle after issue (FIFO registered). Back-to-back fault entries retire one per cycle.
- Full throughput: one issue and one retire per cycle sustained.
- rst mid-operation: all state cleared next edge. Responses arriving after reset for pre-reset requests set spurious_err; sub-units must be reset together with the tracker.

## Structure
- Entry typedef fetch_tracker_entry_t goes in cva5_types. Its subunit_id width constant FETCH_SUBUNIT_ID_W=3 goes in cva5_config. A tracker instantiated with NUM_SUB_UNITS>8 is illegal, enforced by an elaboration assertion.
- Reuse the existing cva5_fifo for attribute storage. Reuse one_hot_to_integer for subunit_id encoding.
- No new sub-module.

## Test plan
- Reset, then 4 valid issues to unit 1 (depth 4). Expect issue_ready=0 after the 4th issue. Respond in order with data 0xA0..0xA3. Expect 4 completes carrying the same data in order; occupancy returns 0.
- Issue to unit 0, then unit 2. Respond with unit 0 data 0x13. Expect complete=1 with data 0x13 and occupancy=1. Pulse unit 2 twice; expect spurious_err=1 after the second pulse.
- Issue 3 requests, then flush while also issuing a 4th. Expect discard_count=4. Return all 4 responses; expect complete to stay 0. A 5th request then completes normally.
- issue_mmu_fault=1 with issue_match=0 into an empty tracker. Expect complete=1, complete_ok=0 one cycle later with no unit strobe.
- Hold full and issue+retire every cycle for 100 cycles with random unit selection. Expect occupancy constant at 4, no spurious_err, and completions matching the issue order exactly.
